// File: rtl/encoder_input_arbiter.sv
// Two-source arbiter feeding the spatial encoder input port.
// Source A (live acquisition) has fixed priority. A burst limit guarantees
// that source B (replay feed) is served after MAX_BURST consecutive A grants
// while B waits. The granted sample is held in a one-entry output buffer that
// is drained through a valid/ready handshake.
module encoder_input_arbiter #(
    parameter int unsigned MAX_BURST      = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned MODE_WIDTH     = 2,
    parameter int unsigned LABEL_WIDTH    = 5,
    parameter int unsigned CHANNEL_WIDTH  = 7,
    parameter int unsigned INPUT_CHANNELS = 4
) (
    input  logic                                    Clk_CI,
    input  logic                                    Reset_RBI,
    input  logic                                    ValidA_SI,
    output logic                                    ReadyA_SO,
    input  logic [MODE_WIDTH-1:0]                   ModeA_SI,
    input  logic [LABEL_WIDTH-1:0]                  LabelA_DI,
    input  logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0] ChannelsA_DI,
    input  logic                                    ValidB_SI,
    output logic                                    ReadyB_SO,
    input  logic [MODE_WIDTH-1:0]                   ModeB_SI,
    input  logic [LABEL_WIDTH-1:0]                  LabelB_DI,
    input  logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0] ChannelsB_DI,
    output logic                                    ValidOut_SO,
    input  logic                                    ReadyIn_SI,
    output logic [MODE_WIDTH-1:0]                   ModeOut_SO,
    output logic [LABEL_WIDTH-1:0]                  LabelOut_DO,
    output logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0] ChannelsOut_DO,
    output logic                                    GrantSrc_SO,
    output logic [CNT_WIDTH-1:0]                    CountA_DO,
    output logic [CNT_WIDTH-1:0]                    CountB_DO
);

    localparam int unsigned CH_W      = CHANNEL_WIDTH * INPUT_CHANNELS;
    localparam logic [3:0]  BURST_MAX = 4'(MAX_BURST);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_burst;
    logic [MODE_WIDTH-1:0]  r_mode;
    logic [LABEL_WIDTH-1:0] r_label;
    logic [CH_W-1:0]        r_channels;
    logic                   r_src;
    logic [CNT_WIDTH-1:0]   r_cnt_a;
    logic [CNT_WIDTH-1:0]   r_cnt_b;

    logic w_empty;
    logic w_force_b;
    logic w_grant_a;
    logic w_grant_b;

    // Grant decision: A wins unless B has waited through a full burst of A grants.
    always_comb begin
        w_empty   = (r_state == ST_EMPTY);
        w_force_b = ValidB_SI && (r_burst == BURST_MAX);
        w_grant_a = w_empty && ValidA_SI && !w_force_b;
        w_grant_b = w_empty && ValidB_SI && !w_grant_a;
    end

    assign ReadyA_SO      = w_grant_a;
    assign ReadyB_SO      = w_grant_b;
    assign ValidOut_SO    = (r_state == ST_FULL);
    assign ModeOut_SO     = r_mode;
    assign LabelOut_DO    = r_label;
    assign ChannelsOut_DO = r_channels;
    assign GrantSrc_SO    = r_src;
    assign CountA_DO      = r_cnt_a;
    assign CountB_DO      = r_cnt_b;

    // Buffer FSM: capture the granted sample when empty, release it on encoder ready.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_state    <= ST_EMPTY;
            r_mode     <= '0;
            r_label    <= '0;
            r_channels <= '0;
            r_src      <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_grant_a) begin
                        r_mode     <= ModeA_SI;
                        r_label    <= LabelA_DI;
                        r_channels <= ChannelsA_DI;
                        r_src      <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (w_grant_b) begin
                        r_mode     <= ModeB_SI;
                        r_label    <= LabelB_DI;
                        r_channels <= ChannelsB_DI;
                        r_src      <= 1'b1;
                        r_state    <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (ReadyIn_SI) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Burst tracker: counts A grants taken while B was waiting, saturating at the limit.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_burst <= '0;
        end else if (w_grant_a) begin
            if (!ValidB_SI) begin
                r_burst <= '0;
            end else if (r_burst != BURST_MAX) begin
                r_burst <= r_burst + 4'd1;
            end
        end else if (w_grant_b) begin
            r_burst <= '0;
        end
    end

    // Per-source accepted-sample counters; free-running, wrap on overflow.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_grant_a) begin
                r_cnt_a <= r_cnt_a + CNT_WIDTH'(1);
            end
            if (w_grant_b) begin
                r_cnt_b <= r_cnt_b + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_encoder_input_arbiter.sv
// Bench for encoder_input_arbiter: reset, vector table, stall/wrap/reset
// sequences and a randomized run against a transaction-level reference model.
module tb_encoder_input_arbiter;

    localparam int MB  = 4;
    localparam int MW  = 2;
    localparam int LW  = 5;
    localparam int CW  = 7;
    localparam int IC  = 4;
    localparam int CHW = CW * IC;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           vA, vB, rdy;
    logic [MW-1:0]  mA, mB;
    logic [LW-1:0]  lA, lB;
    logic [CHW-1:0] cA, cB;

    logic           rA, rB, vo, src;
    logic [MW-1:0]  mo;
    logic [LW-1:0]  lo;
    logic [CHW-1:0] co;
    logic [15:0]    cntA, cntB;

    logic           rA_w, rB_w, vo_w, src_w;
    logic [MW-1:0]  mo_w;
    logic [LW-1:0]  lo_w;
    logic [CHW-1:0] co_w;
    logic [3:0]     cntA_w, cntB_w;

    encoder_input_arbiter #(.MAX_BURST(MB), .CNT_WIDTH(16), .MODE_WIDTH(MW),
        .LABEL_WIDTH(LW), .CHANNEL_WIDTH(CW), .INPUT_CHANNELS(IC)) dut (
        .Clk_CI(clk), .Reset_RBI(rst_n),
        .ValidA_SI(vA), .ReadyA_SO(rA), .ModeA_SI(mA), .LabelA_DI(lA), .ChannelsA_DI(cA),
        .ValidB_SI(vB), .ReadyB_SO(rB), .ModeB_SI(mB), .LabelB_DI(lB), .ChannelsB_DI(cB),
        .ValidOut_SO(vo), .ReadyIn_SI(rdy), .ModeOut_SO(mo), .LabelOut_DO(lo),
        .ChannelsOut_DO(co), .GrantSrc_SO(src), .CountA_DO(cntA), .CountB_DO(cntB));

    // Narrow-counter instance used to observe counter wrap-around.
    encoder_input_arbiter #(.MAX_BURST(MB), .CNT_WIDTH(4), .MODE_WIDTH(MW),
        .LABEL_WIDTH(LW), .CHANNEL_WIDTH(CW), .INPUT_CHANNELS(IC)) dut_w (
        .Clk_CI(clk), .Reset_RBI(rst_n),
        .ValidA_SI(vA), .ReadyA_SO(rA_w), .ModeA_SI(mA), .LabelA_DI(lA), .ChannelsA_DI(cA),
        .ValidB_SI(vB), .ReadyB_SO(rB_w), .ModeB_SI(mB), .LabelB_DI(lB), .ChannelsB_DI(cB),
        .ValidOut_SO(vo_w), .ReadyIn_SI(rdy), .ModeOut_SO(mo_w), .LabelOut_DO(lo_w),
        .ChannelsOut_DO(co_w), .GrantSrc_SO(src_w), .CountA_DO(cntA_w), .CountB_DO(cntB_w));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit seenA, seenB;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference model: one buffer slot, a count of A wins while B waited,
    // and unbounded acceptance totals reduced modulo counter width on compare.
    bit             m_full;
    int             m_streak;
    logic [MW-1:0]  m_mode;
    logic [LW-1:0]  m_label;
    logic [CHW-1:0] m_chan;
    bit             m_src;
    int unsigned    m_cntA, m_cntB;

    function automatic void model_grants(output bit gA, output bit gB);
        bit b_due;
        gA = 1'b0;
        gB = 1'b0;
        if (!m_full) begin
            b_due = vB && (m_streak >= MB);
            gA = vA && !b_due;
            gB = vB && !gA;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit gA, gB;
        if (!rst_n) begin
            m_full = 0; m_streak = 0; m_mode = '0; m_label = '0; m_chan = '0;
            m_src = 0; m_cntA = 0; m_cntB = 0;
        end else if (m_full) begin
            if (rdy) m_full = 0;
        end else begin
            model_grants(gA, gB);
            if (gA) begin
                m_mode = mA; m_label = lA; m_chan = cA; m_src = 0; m_full = 1;
                m_cntA++;
                m_streak = vB ? ((m_streak + 1 > MB) ? MB : m_streak + 1) : 0;
            end else if (gB) begin
                m_mode = mB; m_label = lB; m_chan = cB; m_src = 1; m_full = 1;
                m_cntB++;
                m_streak = 0;
            end
        end
    end

    task automatic model_check();
        bit gA, gB;
        model_grants(gA, gB);
        chk("readyA", rA, gA);
        chk("readyB", rB, gB);
        chk("validOut", vo, m_full);
        chk("readyA_w", rA_w, gA);
        chk("readyB_w", rB_w, gB);
        chk("validOut_w", vo_w, m_full);
        if (m_full) begin
            chk("mode", mo, m_mode);
            chk("label", lo, m_label);
            chk("chan", co, m_chan);
            chk("src", src, m_src);
            chk("mode_w", mo_w, m_mode);
            chk("label_w", lo_w, m_label);
            chk("chan_w", co_w, m_chan);
            chk("src_w", src_w, m_src);
        end
        chk("countA", cntA, m_cntA % 65536);
        chk("countB", cntB, m_cntB % 65536);
        chk("countA_w", cntA_w, m_cntA % 16);
        chk("countB_w", cntB_w, m_cntB % 16);
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        seenA = rA;
        seenB = rB;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vA = 0; vB = 0; rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seenA = 0; seenB = 0;
    endtask

    task automatic new_a();
        mA = MW'($urandom); lA = LW'($urandom); cA = CHW'($urandom);
    endtask

    task automatic new_b();
        mB = MW'($urandom); lB = LW'($urandom); cB = CHW'($urandom);
    endtask

    task automatic feed_a(input int n, input bit chk_gap);
        int got = 0;
        int last = -1;
        int budget = 4 * n + 8;
        vA = 1; new_a();
        while (got < n && budget > 0) begin
            step();
            budget--;
            if (seenA) begin
                got++;
                if (chk_gap && last >= 0) chk("a_gap", cyc - last, 2);
                last = cyc;
                if (got < n) new_a(); else vA = 0;
            end
        end
        if (got < n) begin
            chk("feed_a_budget", got, n);
            vA = 0;
        end
    endtask

    typedef struct {
        bit vA, vB, rdy;
        bit eRA, eRB, eVO, eSrc;
    } vec_t;

    vec_t tbl[26];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [CHW-1:0] held;
        // A,A,A,A,B burst pattern; B alone then A one cycle later; burst cleared after.
        tbl[0]  = '{1,1,1, 1,0,0,0}; tbl[1]  = '{1,1,1, 0,0,1,0};
        tbl[2]  = '{1,1,1, 1,0,0,0}; tbl[3]  = '{1,1,1, 0,0,1,0};
        tbl[4]  = '{1,1,1, 1,0,0,0}; tbl[5]  = '{1,1,1, 0,0,1,0};
        tbl[6]  = '{1,1,1, 1,0,0,0}; tbl[7]  = '{1,1,1, 0,0,1,0};
        tbl[8]  = '{1,1,1, 0,1,0,0}; tbl[9]  = '{1,1,1, 0,0,1,1};
        tbl[10] = '{1,1,1, 1,0,0,0}; tbl[11] = '{0,1,1, 0,0,1,0};
        tbl[12] = '{0,1,1, 0,1,0,0}; tbl[13] = '{1,0,1, 0,0,1,1};
        tbl[14] = '{1,0,1, 1,0,0,0}; tbl[15] = '{0,0,1, 0,0,1,0};
        tbl[16] = '{1,1,1, 1,0,0,0}; tbl[17] = '{1,1,1, 0,0,1,0};
        tbl[18] = '{1,1,1, 1,0,0,0}; tbl[19] = '{1,1,1, 0,0,1,0};
        tbl[20] = '{1,1,1, 1,0,0,0}; tbl[21] = '{1,1,1, 0,0,1,0};
        tbl[22] = '{1,1,1, 1,0,0,0}; tbl[23] = '{1,1,1, 0,0,1,0};
        tbl[24] = '{1,1,1, 0,1,0,0}; tbl[25] = '{1,1,1, 0,0,1,1};

        vA = 0; vB = 0; rdy = 0;
        mA = '0; lA = '0; cA = '0; mB = '0; lB = '0; cB = '0;
        #1;
        do_reset();

        // Reset state
        chk("rst_validOut", vo, 0);
        chk("rst_readyA", rA, 0);
        chk("rst_readyB", rB, 0);
        chk("rst_mode", mo, 0);
        chk("rst_label", lo, 0);
        chk("rst_chan", co, 0);
        chk("rst_src", src, 0);
        chk("rst_countA", cntA, 0);
        chk("rst_countB", cntB, 0);
        chk("rst_countA_w", cntA_w, 0);

        // A only, encoder always ready: 10 samples at 2-cycle spacing
        rdy = 1;
        feed_a(10, 1);
        step();
        chk("t1_countA", cntA, 10);
        chk("t1_countB", cntB, 0);

        // Vector table
        do_reset();
        mA = 2'd1; lA = 5'd3;  cA = 28'hA5A5A5A;
        mB = 2'd2; lB = 5'd17; cB = 28'h5C3C3C3;
        foreach (tbl[i]) begin
            vA = tbl[i].vA; vB = tbl[i].vB; rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_readyA", i), rA, tbl[i].eRA);
            chk($sformatf("tbl%0d_readyB", i), rB, tbl[i].eRB);
            chk($sformatf("tbl%0d_validOut", i), vo, tbl[i].eVO);
            if (tbl[i].eVO) begin
                chk($sformatf("tbl%0d_src", i), src, tbl[i].eSrc);
                chk($sformatf("tbl%0d_chan", i), co, tbl[i].eSrc ? 28'h5C3C3C3 : 28'hA5A5A5A);
            end
            model_check();
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("tbl_countA", cntA, 10);
        chk("tbl_countB", cntB, 3);

        // Encoder stall for 7 cycles while the buffer is full
        vA = 1; vB = 1; rdy = 0;
        held = cA;
        step();
        new_a();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("stall_validOut", vo, 1);
            chk("stall_chan", co, held);
            chk("stall_src", src, 0);
            chk("stall_readyA", rA, 0);
            chk("stall_readyB", rB, 0);
            model_check();
            cyc++;
            @(posedge clk);
            #1;
        end
        rdy = 1;
        step();
        @(negedge clk);
        chk("release_validOut", vo, 0);
        chk("release_regrantA", rA, 1);
        model_check();
        cyc++;
        @(posedge clk);
        #1;
        vA = 0; vB = 0;
        step();

        // Counter wrap on the 4-bit instance
        do_reset();
        rdy = 1;
        feed_a(15, 0);
        step();
        chk("wrap_pre_countA_w", cntA_w, 15);
        feed_a(1, 0);
        step();
        chk("wrap_countA_w", cntA_w, 0);
        chk("wrap_countB_w", cntB_w, 0);
        chk("wrap_countA", cntA, 16);

        // Asynchronous reset while the buffer is full
        rdy = 0; vA = 1; new_a();
        step();
        vA = 0;
        chk("pre_arst_validOut", vo, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_validOut", vo, 0);
        chk("arst_countA", cntA, 0);
        chk("arst_countB", cntB, 0);
        chk("arst_validOut_w", vo_w, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seenA = 0; seenB = 0;
        vA = 1; rdy = 1; new_a();
        held = cA;
        step();
        chk("arst_then_grantA", seenA, 1);
        vA = 0;
        @(negedge clk);
        chk("arst_then_chan", co, held);
        chk("arst_then_countA", cntA, 1);
        model_check();
        cyc++;
        @(posedge clk);
        #1;

        // Randomized traffic obeying the source handshake
        do_reset();
        new_a(); new_b();
        for (int k = 0; k < 600; k++) begin
            if (!vA || seenA) begin
                vA = ($urandom_range(0, 3) != 0);
                new_a();
            end
            if (!vB || seenB) begin
                vB = ($urandom_range(0, 4) < 3);
                new_b();
            end
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
